// File: rtl/game_pkg.sv
// game_pkg: round states, LFSR mask and default board sizing shared by the
// board generator, guess checker and guess counter.
package game_pkg;

   typedef enum logic [1:0] {IDLE, FILL, SHOW, READY} state_t;

   localparam logic [15:0] LFSR_MASK          = 16'hB400;
   localparam int          DEFAULT_BOARD_BITS = 8;
   localparam int          DEFAULT_NUM_LIT    = 3;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
module lfsr16
   import game_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] state
);

   logic [15:0] state_q, state_d;

   always_comb state_d = state_q[0] ? (state_q >> 1) ^ LFSR_MASK : state_q >> 1;

   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= SEED;
      else       state_q <= state_d;

   assign state = state_q;

endmodule

// File: rtl/board_generator.sv
// board_generator: builds a random board with NUM_LIT tiles lit, shows it for
// SHOW_CYCLES, then hides it and holds it with ready high for the guess checker.
module board_generator
   import game_pkg::*;
#(
   parameter int          BOARD_BITS  = DEFAULT_BOARD_BITS,
   parameter int          NUM_LIT     = DEFAULT_NUM_LIT,
   parameter int          SHOW_CYCLES = 50_000_000,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [BOARD_BITS-1:0] board,
   output logic [BOARD_BITS-1:0] display,
   output logic                  ready,
   output logic                  busy
);

   localparam int IDX_W = $clog2(BOARD_BITS);
   localparam int CNT_W = IDX_W + 1;
   localparam int TMR_W = SHOW_CYCLES > 1 ? $clog2(SHOW_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LIT      = CNT_W'(NUM_LIT);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SHOW_CYCLES - 1);

   logic [15:0]           lfsr;
   logic [IDX_W-1:0]      idx;
   logic                  unused_lfsr;
   state_t                state_q, state_d;
   logic [BOARD_BITS-1:0] board_q, board_d, display_q, display_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   logic                  ready_q, ready_d, busy_q, busy_d;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .state(lfsr));

   assign idx         = lfsr[IDX_W-1:0];
   assign unused_lfsr = ^lfsr[15:IDX_W];

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_comb begin
      state_d = state_q;
      board_d = board_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      case (state_q)
         IDLE, READY:
            if (start) begin
               state_d = FILL;
               board_d = '0;
               cnt_d   = '0;
            end
         FILL:
            if (!board_q[idx]) begin
               board_d[idx] = 1'b1;
               cnt_d        = cnt_q + CNT_W'(1);
               if (cnt_d == LIT) begin
                  state_d = SHOW;
                  tmr_d   = TMR_LOAD;
               end
            end
         SHOW:
            if (tmr_q == '0) state_d = READY;
            else             tmr_d   = tmr_q - TMR_W'(1);
         default: ;
      endcase
      display_d = state_d == SHOW ? board_d : '0;
      ready_d   = state_d == READY;
      busy_d    = state_d == FILL || state_d == SHOW;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q   <= IDLE;
         board_q   <= '0;
         display_q <= '0;
         cnt_q     <= '0;
         tmr_q     <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         board_q   <= board_d;
         display_q <= display_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end

   assign board   = board_q;
   assign display = display_q;
   assign ready   = ready_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_board_generator.sv
// tb_board_generator: scoreboard bench running an 8/3 and a 16/15 board generator
// side by side against a cycle-indexed reference of the round rules.
module tb_board_generator;

   localparam int          S    = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   typedef struct {
      logic [15:0] b;
      int          f;
   } exp_t;

   logic clk = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] step(logic [15:0] v);
      return v[0] ? (v >> 1) ^ 16'hB400 : v >> 1;
   endfunction

   function automatic logic [15:0] lfsr_at(int k);
      logic [15:0] v = SEED;
      for (int i = 0; i < k; i++) v = step(v);
      return v;
   endfunction

   // k = LFSR step count in the first FILL cycle; returns board and FILL length
   function automatic void predict(int k, int bb, int nl, output logic [15:0] b, output int f);
      logic [15:0] v = lfsr_at(k);
      b = '0;
      f = 0;
      while ($countones(b) < nl) begin
         b[int'(v) % bb] = 1'b1;
         v = step(v);
         f++;
      end
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int BB = g ? 16 : 8;
      localparam int NL = g ? 15 : 3;

      logic          reset = 1'b1;
      logic          start = 1'b0;
      logic          ready, busy;
      logic [BB-1:0] board, display;
      int            cyc, next_ok;
      exp_t          q[$];
      exp_t          pe, got;
      int            fl = 0, sl = 0, rounds = 0;
      logic          pr = 1'b0, varied = 1'b0, done = 1'b0;
      logic [BB-1:0] last_b, first_b;

      board_generator #(
         .BOARD_BITS(BB), .NUM_LIT(NL), .SHOW_CYCLES(S), .LFSR_SEED(SEED)
      ) dut (
         .clk(clk), .reset(reset), .start(start),
         .board(board), .display(display), .ready(ready), .busy(busy)
      );

      always @(posedge clk or posedge reset)
         if (reset) cyc <= 0;
         else       cyc <= cyc + 1;

      // Predictor: a start seen while no round is in progress opens a round.
      always @(negedge clk)
         if (reset) begin
            q.delete();
            next_ok = 0;
         end else if (start && cyc >= next_ok) begin
            predict(cyc + 1, BB, NL, pe.b, pe.f);
            q.push_back(pe);
            next_ok = cyc + pe.f + S + 1;
         end

      always @(negedge clk)
         if (reset) begin
            chk("reset_board", board, 0);
            chk("reset_display", display, 0);
            chk("reset_flags", {ready, busy}, 0);
            fl = 0;
            sl = 0;
            pr = 1'b0;
         end else begin
            chk("ready_busy_excl", ready & busy, 0);
            if (busy && display == 0) fl++;
            if (display != 0) begin
               sl++;
               chk("show_display", display, board);
            end
            if (!busy && !ready) chk("idle_outputs", board | display, 0);
            if (ready && !pr) begin
               chk("ready_expected", q.size() > 0, 1);
               if (q.size() > 0) begin
                  got = q.pop_front();
                  chk("board", board, got.b[BB-1:0]);
                  chk("fill_len", fl, got.f);
                  chk("show_len", sl, S);
                  chk("popcount", $countones(board), NL);
                  chk("ready_display", display, 0);
               end
               rounds++;
               if (rounds == 1) first_b = board;
               else if (board != first_b) varied = 1'b1;
               last_b = board;
               fl = 0;
               sl = 0;
            end else if (ready) begin
               chk("ready_hold_board", board, last_b);
               chk("ready_hold_display", display, 0);
            end
            pr = ready;
         end

      task automatic pulse_start();
         @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      endtask

      task automatic wait_ready(string nm);
         int i = 0;
         while (!ready && i < 3000) begin
            @(negedge clk);
            i++;
         end
         chk(nm, ready, 1);
      endtask

      initial begin
         int i;
         repeat (3) @(posedge clk);
         #2 reset = 1'b0;
         repeat (10) @(posedge clk);
         pulse_start();
         wait_ready("round_single");
         repeat (20) @(posedge clk);
         // start held through a whole round, then honoured again from READY
         #1 start = 1'b1;
         wait_ready("round_held");
         i = 0;
         while (ready && i < 50) begin
            @(negedge clk);
            i++;
         end
         chk("held_restart", ready, 0);
         @(posedge clk);
         #1 start = 1'b0;
         wait_ready("round_held_second");
         repeat (5) @(posedge clk);
         pulse_start();
         i = 0;
         while (display == 0 && i < 3000) begin
            @(negedge clk);
            i++;
         end
         chk("show_reached", display != 0, 1);
         #2 reset = 1'b1;
         #1;
         chk("async_board", board, 0);
         chk("async_display", display, 0);
         chk("async_flags", {ready, busy}, 0);
         for (int r = 0; r < 2; r++) begin
            repeat (2) @(posedge clk);
            #2 reset = 1'b0;
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            wait_ready("round_after_reset");
            @(posedge clk);
            #2 reset = 1'b1;
         end
         repeat (2) @(posedge clk);
         #2 reset = 1'b0;
         for (int r = 0; r < 50; r++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            pulse_start();
            wait_ready("round_random");
         end
         repeat (3) @(posedge clk);
         chk("pending_rounds", q.size(), 0);
         chk("boards_vary", varied, 1);
         done = 1'b1;
      end
   end

   initial begin
      wait (cfg[0].done && cfg[1].done);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: bench did not complete, %0d of %0d checks failed so far", n_chk - n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/board_generator.md
# board_generator

Produces the hidden tile pattern for one Memory Matrix round and drives the show-then-hide sequence. Sits between the top-level start key and the guess-checking logic. On a start pulse it builds a random board with exactly NUM_LIT tiles set, displays it for SHOW_CYCLES, then blanks the display. It holds the board stable with `ready` high so the checker can compare player guesses against it.

## Interface
- BOARD_BITS, 8: number of tiles; power of two, 2..16.
- NUM_LIT, 3: tiles lit per round; 1..BOARD_BITS-1.
- SHOW_CYCLES, 50_000_000: display time in clk cycles (1 s at 50 MHz); minimum 1.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request new round; sampled each cycle, level-high counts once per cycle.
- board  out  BOARD_BITS  hidden pattern; valid when `ready`=1.
- display  out  BOARD_BITS  pattern to LEDs: equals `board` in SHOW, else 0.
- ready  out  1  board complete and hidden; guessing may proceed.
- busy  out  1  high in FILL and SHOW.

## Operation
- 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (shift right; XOR mask 16'hB400 when LSB=1).
  - Advances every cycle in every state.
  - The round pattern therefore depends on when `start` arrives.
- idx = lfsr[IDX_W-1:0], where IDX_W = clog2(BOARD_BITS).
- FSM states: IDLE, FILL, SHOW, READY.
- IDLE: outputs 0. `start`=1 → FILL; clear board, clear lit count.
- FILL, each cycle:
  - If board[idx]=0: set it and increment the lit count.
  - If board[idx]=1: no change.
  - When the increment brings the count to NUM_LIT → SHOW; load the show timer with SHOW_CYCLES-1.
  - `start` is ignored.
- SHOW: `display`=`board`. The timer decrements each cycle; at timer=0 → READY. `start` is ignored.
- READY:
  - `ready`=1, `display`=0, `board` held.
  - `start`=1 → FILL; board cleared, `ready` drops the next cycle. This begins a new round.
- Lit count is clog2(BOARD_BITS)+1 bits wide and never exceeds NUM_LIT. The board always has popcount exactly NUM_LIT when leaving FILL.
- Reset (any time, including mid-FILL/SHOW):
  - State=IDLE; board, display, ready, busy, count and timer = 0; LFSR=LFSR_SEED.
  - Takes effect immediately (asynchronous).

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `start` to any output.
- `start` high in IDLE at edge n: busy=1 and board=0 after edge n; first tile possibly set at edge n+1.
- FILL lasts at least NUM_LIT cycles. It is data-dependent but deterministic for a given seed and start cycle.
- SHOW lasts exactly SHOW_CYCLES cycles with `display` nonzero.
- `ready` rises on the same edge that `display` goes to 0 and `busy` falls.
- A `start` asserted on the same cycle as the SHOW→READY transition is ignored. A `start` in READY is honoured one cycle later.

## Structure
- Shared package (game_pkg) holds:
  - the state enum (IDLE/FILL/SHOW/READY);
  - the LFSR mask constant 16'hB400;
  - the default BOARD_BITS and NUM_LIT. These are shared with the guess checker and guess counter.
- One sub-module: lfsr16 (clk, reset, seed parameter, 16-bit state out, advance every cycle).
- FSM, count and timer live in board_generator.

## Test plan
Run with SHOW_CYCLES=4 for simulation.
1. Reset held 3 cycles, then released with start=0 for 10 cycles → board=0, display=0, ready=0, busy=0 throughout.
2. Single start pulse → busy=1 next cycle; FILL ends with popcount(board)=3; display=board for exactly 4 cycles; then ready=1, display=0, board unchanged for 20 cycles.
3. start held high through FILL and SHOW → no restart, board unchanged, ready rises once. In READY, the held start immediately begins a second round with a freshly filled board.
4. Reset asserted mid-SHOW → all outputs 0 immediately. Two runs with an identical start cycle after reset yield an identical board (LFSR reloaded to 16'hACE1).
5. Parameter sweep BOARD_BITS=16, NUM_LIT=15 → popcount=15 each round over 50 rounds, with no hang in FILL.
6. start pulses at 50 different cycle offsets → board values vary. Every round has popcount=NUM_LIT and no bit above BOARD_BITS-1 is ever set.
